// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes and FSM states.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CALC  = 2'b01,
    ST_FIXUP = 2'b10,
    ST_DONE  = 2'b11
  } md_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the CPU control unit (master) and the muldiv unit (slave).
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  import muldiv_pkg::*;

  logic             start;
  md_op_e           op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clear;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, clear,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, a, b, clear,
    output hi, lo, busy, done, div_by_zero
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and divide sharing one 2*WIDTH accumulator,
// holding the HI/LO result registers. WIDTH must be even and at least 4.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;

  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;

  logic               op_signed;
  logic               op_div;
  logic               sign_a;
  logic               sign_b;
  logic               zero_div;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] acc_neg;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

  // Decode the incoming request into operand magnitudes and sign flags.
  always_comb begin
    op_signed = ~bus.op[0];
    op_div    = bus.op[1];
    sign_a    = op_signed & bus.a[WIDTH-1];
    sign_b    = op_signed & bus.b[WIDTH-1];
    abs_a     = sign_a ? -bus.a : bus.a;
    abs_b     = sign_b ? -bus.b : bus.b;
    zero_div  = op_div && (bus.b == '0);
  end

  // One iteration of shift-add (multiply) or restoring shift-subtract (divide),
  // plus the two's-complement fixups applied after the last iteration.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : {WIDTH{1'b0}})};
    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, mag_b};
    acc_next  = acc;
    if (is_div) begin
      if (div_trial[WIDTH]) begin
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
    acc_neg  = -acc;
    quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Control FSM and datapath registers; reset and clear abort everything and zero the results.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      state   <= ST_IDLE;
      count   <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            busy_q  <= 1'b1;
            is_div  <= op_div;
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            mag_a   <= abs_a;
            mag_b   <= abs_b;
            if (zero_div) begin
              state <= ST_DONE;
            end else begin
              state <= ST_CALC;
              count <= CW'(WIDTH - 1);
              acc   <= op_div ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
            end
          end
        end
        ST_CALC: begin
          acc <= acc_next;
          if (count == '0) begin
            state <= ST_FIXUP;
          end else begin
            count <= count - 1'b1;
          end
        end
        ST_FIXUP: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quot_fix;
          end else begin
            {hi_q, lo_q} <= neg_res ? acc_neg : acc;
          end
          dbz_q  <= 1'b0;
          done_q <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          // A divide-by-zero arrives here without done raised; raise it one cycle later.
          if (done_q) begin
            done_q <= 1'b0;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            done_q <= 1'b1;
            dbz_q  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;
  int lat;
  logic busy1;
  logic done_seen;

  muldiv_unit_if #(.WIDTH(32)) bus32 ();
  muldiv_unit_if #(.WIDTH(8))  bus8 ();

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation in the next cycle, then count cycles until done (bounded).
  task automatic apply_stimulus(input bit narrow, input md_op_e op, input logic [31:0] a,
                                input logic [31:0] b, output int latency, output logic busy_first);
    @(negedge clk);
    if (narrow) begin
      bus8.start = 1'b1;
      bus8.op    = op;
      bus8.a     = a[7:0];
      bus8.b     = b[7:0];
    end else begin
      bus32.start = 1'b1;
      bus32.op    = op;
      bus32.a     = a;
      bus32.b     = b;
    end
    @(negedge clk);
    bus8.start  = 1'b0;
    bus32.start = 1'b0;
    latency     = 1;
    busy_first  = narrow ? bus8.busy : bus32.busy;
    while (!(narrow ? bus8.done : bus32.done) && latency < 200) begin
      @(negedge clk);
      latency++;
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus32.start = 1'b0;
    bus32.clear = 1'b0;
    bus32.op    = MD_MULT;
    bus32.a     = '0;
    bus32.b     = '0;
    bus8.start  = 1'b0;
    bus8.clear  = 1'b0;
    bus8.op     = MD_MULT;
    bus8.a      = '0;
    bus8.b      = '0;
    repeat (3) @(negedge clk);
    check_output("rst_hilo32", {bus32.hi, bus32.lo}, 64'h0);
    check_output("rst_flags32", {61'h0, bus32.busy, bus32.done, bus32.div_by_zero}, 64'h0);
    check_output("rst_hilo8", {48'h0, bus8.hi, bus8.lo}, 64'h0);
    check_output("rst_flags8", {61'h0, bus8.busy, bus8.done, bus8.div_by_zero}, 64'h0);
    reset = 1'b0;

    $display("[TB] MULTU max x max");
    apply_stimulus(1'b0, MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, busy1);
    check_output("multu_lat", 64'(lat), 64'd34);
    check_output("multu_busy", {63'h0, busy1}, 64'h1);
    check_output("multu_hilo", {bus32.hi, bus32.lo}, 64'hFFFFFFFE_00000001);
    check_output("multu_dbz", {63'h0, bus32.div_by_zero}, 64'h0);
    @(negedge clk);
    check_output("multu_after", {62'h0, bus32.busy, bus32.done}, 64'h0);

    $display("[TB] signed multiply and divide");
    apply_stimulus(1'b0, MD_MULT, 32'hFFFFFFF9, 32'd3, lat, busy1);
    check_output("mult_lat", 64'(lat), 64'd34);
    check_output("mult_hilo", {bus32.hi, bus32.lo}, 64'hFFFFFFFF_FFFFFFEB);
    apply_stimulus(1'b0, MD_DIV, 32'hFFFFFFF9, 32'd2, lat, busy1);
    check_output("div_hilo", {bus32.hi, bus32.lo}, 64'hFFFFFFFF_FFFFFFFD);
    apply_stimulus(1'b0, MD_DIVU, 32'd7, 32'd2, lat, busy1);
    check_output("divu_hilo", {bus32.hi, bus32.lo}, 64'h00000001_00000003);

    $display("[TB] divide by zero");
    apply_stimulus(1'b0, MD_DIVU, 32'h451, 32'h20, lat, busy1);
    check_output("setup_hilo", {bus32.hi, bus32.lo}, 64'h00000011_00000022);
    apply_stimulus(1'b0, MD_DIV, 32'd5, 32'd0, lat, busy1);
    check_output("dbz_lat", 64'(lat), 64'd2);
    check_output("dbz_busy", {63'h0, busy1}, 64'h1);
    check_output("dbz_flag", {63'h0, bus32.div_by_zero}, 64'h1);
    check_output("dbz_hilo", {bus32.hi, bus32.lo}, 64'h00000011_00000022);

    $display("[TB] signed overflow");
    apply_stimulus(1'b0, MD_DIV, 32'h80000000, 32'hFFFFFFFF, lat, busy1);
    check_output("ovf_hilo", {bus32.hi, bus32.lo}, 64'h00000000_80000000);
    check_output("ovf_dbz", {63'h0, bus32.div_by_zero}, 64'h0);

    $display("[TB] reset mid-calculation");
    @(negedge clk);
    bus32.start = 1'b1;
    bus32.op    = MD_MULTU;
    bus32.a     = 32'd3;
    bus32.b     = 32'd5;
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (8) @(negedge clk);
    check_output("abort_busy_pre", {63'h0, bus32.busy}, 64'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_output("abort_busy", {63'h0, bus32.busy}, 64'h0);
    check_output("abort_hilo", {bus32.hi, bus32.lo}, 64'h0);
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.done) done_seen = 1'b1;
    end
    check_output("abort_nodone", {63'h0, done_seen}, 64'h0);

    $display("[TB] start while busy is ignored");
    @(negedge clk);
    bus32.start = 1'b1;
    bus32.op    = MD_MULTU;
    bus32.a     = 32'd6;
    bus32.b     = 32'd7;
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (3) @(negedge clk);
    bus32.start = 1'b1;
    bus32.a     = 32'd100;
    bus32.b     = 32'd100;
    @(negedge clk);
    bus32.start = 1'b0;
    lat = 5;
    while (!bus32.done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check_output("ign_lat", 64'(lat), 64'd34);
    check_output("ign_hilo", {bus32.hi, bus32.lo}, 64'd42);

    $display("[TB] clear with simultaneous start");
    @(negedge clk);
    @(negedge clk);
    bus32.clear = 1'b1;
    bus32.start = 1'b1;
    @(negedge clk);
    bus32.clear = 1'b0;
    bus32.start = 1'b0;
    check_output("clr_hilo", {bus32.hi, bus32.lo}, 64'h0);
    check_output("clr_busy", {63'h0, bus32.busy}, 64'h0);

    $display("[TB] WIDTH=8 and back-to-back");
    apply_stimulus(1'b1, MD_MULT, 32'h80, 32'h80, lat, busy1);
    check_output("w8_lat", 64'(lat), 64'd10);
    check_output("w8_hilo", {48'h0, bus8.hi, bus8.lo}, 64'h4000);
    apply_stimulus(1'b1, MD_MULTU, 32'hFF, 32'hFF, lat, busy1);
    check_output("w8_b2b_lat", 64'(lat), 64'd10);
    check_output("w8_b2b_hilo", {48'h0, bus8.hi, bus8.lo}, 64'hFE01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
